hdmi_mode_switcher: RTL and testbench
=====================================

# hdmi_mode_switcher

Glitch-free selector between NUM_MODES HDMI timing/encoder instances (e.g. 480p60, 576p50, future modes) feeding one serializer. It replaces the fixed two-way PAL/NTSC mux with a sequenced switch. The old mode finishes its frame, all generators are held in reset while the link carries control symbols, and the new mode is released and allowed to settle. Output resumes exactly at pixel (0,0) of a new frame. Sits between the `hdmi_output` instances and the serializer, in the clk_pixel domain.

## Interface
- NUM_MODES, 2, number of selectable timing generators (≥2)
- NUM_CHANNELS, 3, TMDS channels per mode
- RESET_CYCLES, 16, cycles all generators are held in reset during a switch (≥1)
- SETTLE_FRAMES, 2, frames of the new mode discarded before unblanking (≥1)
- BLANK_SYMBOL, 10'b1101010100, TMDS word driven on every channel while blanked
- MODE_W (localparam), $clog2(NUM_MODES)

Ports:
- clk_pixel  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high
- mode_req  in  MODE_W  requested mode index, clk_pixel-synchronous
- tmds_in  in  NUM_MODES*NUM_CHANNELS*10  mode m, channel c at [(m*NUM_CHANNELS+c)*10 +: 10]
- cx_in  in  NUM_MODES*11  mode m at [m*11 +: 11]
- cy_in  in  NUM_MODES*10  mode m at [m*10 +: 10]
- tmds_out  out  NUM_CHANNELS*10  selected or blank words, registered
- cx  out  11  selected cx, registered, aligned with tmds_out
- cy  out  10  selected cy, registered, aligned with tmds_out
- mode_reset  out  NUM_MODES  per-generator reset, registered
- active_mode  out  MODE_W  mode currently being output, or last mode output
- busy  out  1  high in every state except STEADY
- audio_mute  out  1  high in BLANK and SETTLE

## Operation
- Frame boundary of mode m: cx_in[m]==0 && cy_in[m]==0 in the current cycle.
- States are RESET_SEQ/BLANK, SETTLE, STEADY and DRAIN. All outputs are registers loaded from the next-state decode.
- Reset: state←BLANK, target←mode_req (0 if mode_req≥NUM_MODES), counter←RESET_CYCLES, active_mode←0, mode_reset←all 1, tmds_out←BLANK_SYMBOL on all channels, cx←0, cy←0, busy←1, audio_mute←1. Power-up uses the normal switch path.
- STEADY: tmds_out/cx/cy ← inputs of active_mode; mode_reset = ~onehot(active_mode). If mode_req≠active_mode and mode_req<NUM_MODES, go to DRAIN with target←mode_req. Out-of-range requests are ignored.
- DRAIN: active_mode keeps streaming; target tracks mode_req every cycle, ignoring out-of-range values.
  - If mode_req returns to active_mode, go to STEADY with no blanking.
  - On the active mode's frame boundary, go to BLANK and load the counter with RESET_CYCLES. In that same cycle the output register loads BLANK_SYMBOL, so pixel (0,0) of the old mode is never emitted.
- BLANK: mode_reset all 1; output blank; counter decrements. When the counter reaches 1, go to SETTLE with mode_reset←~onehot(target) and frame counter←0. mode_reset stays all-1 for exactly RESET_CYCLES cycles.
- SETTLE: output blank; each frame boundary of target increments the frame counter. On the SETTLE_FRAMES-th boundary, go to STEADY with active_mode←target. In that same cycle the output loads target's words, so the first unblanked symbol is pixel (0,0).
- mode_req changes during BLANK/SETTLE are ignored; they are re-evaluated on the first STEADY cycle.
- reset asserted in any state restarts the reset sequence immediately.

## Timing
- Steady-state latency from tmds_in/cx_in/cy_in to outputs is 1 cycle. tmds_out, cx and cy are always mutually aligned.
- Boundary seen at cycle t in DRAIN gives BLANK_SYMBOL and busy/audio_mute=1 at t+1, and mode_reset all 1 from t+1 to t+RESET_CYCLES.
- Switch duration = (cycles to old frame end) + RESET_CYCLES + SETTLE_FRAMES frames of the new mode.
- In every cycle, mode_reset of active_mode is 0 when state∈{STEADY, DRAIN}.

## Test plan
- Reset with mode_req=1, NUM_MODES=2, RESET_CYCLES=16, SETTLE_FRAMES=2:
  - mode_reset=2'b11 for 16 cycles after reset deasserts, then 2'b01.
  - Output blank until mode 1's 2nd (0,0); then tmds_out=mode 1 words from pixel (0,0), active_mode=1, busy=0.
- STEADY mode 0, mode_req→1 mid-frame: mode 0 words continue to the end of the frame. Blank begins exactly where mode 0 reaches (0,0); no partial-frame symbol of mode 1 ever appears.
- DRAIN abort: mode_req 0→1→0 before mode 0's boundary. Expected: busy pulses, with no blank symbol, mode_reset stays 2'b10, and no gap in mode 0 words.
- NUM_MODES=3: requests 2, then 3 (out of range). Switch to 2 completes; request 3 is ignored and active_mode stays 2.
- mode_req toggles during SETTLE: the ongoing switch completes to the original target, then a new DRAIN starts in the first STEADY cycle.
- reset asserted mid-SETTLE: all outputs take their reset values on the next edge, and the sequence restarts with a full RESET_CYCLES hold.

Source files
------------

// File: rtl/hdmi_mode_switcher.sv
// Glitch-free sequenced selector between several HDMI timing/encoder instances.
// Switches drain the old frame, hold all generators in reset, then settle the new mode.
module hdmi_mode_switcher #(
  parameter int         NUM_MODES     = 2,
  parameter int         NUM_CHANNELS  = 3,
  parameter int         RESET_CYCLES  = 16,
  parameter int         SETTLE_FRAMES = 2,
  parameter logic [9:0] BLANK_SYMBOL  = 10'b1101010100,
  localparam int        MODE_W        = $clog2(NUM_MODES)
) (
  input  logic                              clk_pixel,
  input  logic                              reset,
  input  logic [MODE_W-1:0]                 mode_req,
  input  logic [NUM_MODES*NUM_CHANNELS*10-1:0] tmds_in,
  input  logic [NUM_MODES*11-1:0]           cx_in,
  input  logic [NUM_MODES*10-1:0]           cy_in,
  output logic [NUM_CHANNELS*10-1:0]        tmds_out,
  output logic [10:0]                       cx,
  output logic [9:0]                        cy,
  output logic [NUM_MODES-1:0]              mode_reset,
  output logic [MODE_W-1:0]                 active_mode,
  output logic                              busy,
  output logic                              audio_mute
);

  localparam int WORDS_W = NUM_CHANNELS * 10;
  localparam int CNT_W   = $clog2(RESET_CYCLES + 1);
  localparam int FRM_W   = $clog2(SETTLE_FRAMES + 1);
  localparam logic [MODE_W:0]    MODE_LIMIT = (MODE_W + 1)'(NUM_MODES);
  localparam logic [NUM_MODES-1:0] MODE_ONE = NUM_MODES'(1);

  typedef enum logic [1:0] {ST_BLANK, ST_SETTLE, ST_STEADY, ST_DRAIN} state_t;

  state_t              state, state_n;
  logic [MODE_W-1:0]   target, target_n;
  logic [MODE_W-1:0]   active_n, src;
  logic [CNT_W-1:0]    count, count_n;
  logic [FRM_W-1:0]    frames, frames_n;
  logic [NUM_MODES-1:0] mode_reset_n;
  logic [WORDS_W-1:0]  tmds_n;
  logic [10:0]         cx_n;
  logic [9:0]          cy_n;
  logic                busy_n, mute_n, blank;
  logic                req_ok, at_active, at_target;

  assign req_ok    = ({1'b0, mode_req} < MODE_LIMIT);
  assign at_active = (cx_in[int'(active_mode)*11 +: 11] == '0) &&
                     (cy_in[int'(active_mode)*10 +: 10] == '0);
  assign at_target = (cx_in[int'(target)*11 +: 11] == '0) &&
                     (cy_in[int'(target)*10 +: 10] == '0);

  always_comb begin
    state_n      = state;
    target_n     = target;
    count_n      = count;
    frames_n     = frames;
    active_n     = active_mode;
    mode_reset_n = mode_reset;
    src          = active_mode;
    blank        = 1'b1;
    case (state)
      ST_STEADY: begin
        blank        = 1'b0;
        mode_reset_n = ~(MODE_ONE << active_mode);
        if (req_ok && (mode_req != active_mode)) begin
          state_n  = ST_DRAIN;
          target_n = mode_req;
        end
      end
      ST_DRAIN: begin
        mode_reset_n = ~(MODE_ONE << active_mode);
        if (mode_req == active_mode) begin
          state_n = ST_STEADY;
          blank   = 1'b0;
        end else begin
          if (req_ok) target_n = mode_req;
          // Blank on the boundary cycle itself so the old (0,0) never leaves.
          if (at_active) begin
            state_n      = ST_BLANK;
            count_n      = CNT_W'(RESET_CYCLES);
            mode_reset_n = '1;
          end else begin
            blank = 1'b0;
          end
        end
      end
      ST_BLANK: begin
        if (count == CNT_W'(1)) begin
          state_n      = ST_SETTLE;
          mode_reset_n = ~(MODE_ONE << target);
          frames_n     = '0;
        end else begin
          count_n = count - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (at_target) begin
          if (frames == FRM_W'(SETTLE_FRAMES - 1)) begin
            state_n  = ST_STEADY;
            active_n = target;
            src      = target;
            blank    = 1'b0;
          end else begin
            frames_n = frames + 1'b1;
          end
        end
      end
      default: state_n = ST_BLANK;
    endcase

    tmds_n = blank ? {NUM_CHANNELS{BLANK_SYMBOL}} : tmds_in[int'(src)*WORDS_W +: WORDS_W];
    cx_n   = blank ? 11'd0 : cx_in[int'(src)*11 +: 11];
    cy_n   = blank ? 10'd0 : cy_in[int'(src)*10 +: 10];
    busy_n = (state_n != ST_STEADY);
    mute_n = (state_n == ST_BLANK) || (state_n == ST_SETTLE);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state       <= ST_BLANK;
      target      <= req_ok ? mode_req : '0;
      count       <= CNT_W'(RESET_CYCLES);
      frames      <= '0;
      active_mode <= '0;
      mode_reset  <= '1;
      tmds_out    <= {NUM_CHANNELS{BLANK_SYMBOL}};
      cx          <= '0;
      cy          <= '0;
      busy        <= 1'b1;
      audio_mute  <= 1'b1;
    end else begin
      state       <= state_n;
      target      <= target_n;
      count       <= count_n;
      frames      <= frames_n;
      active_mode <= active_n;
      mode_reset  <= mode_reset_n;
      tmds_out    <= tmds_n;
      cx          <= cx_n;
      cy          <= cy_n;
      busy        <= busy_n;
      audio_mute  <= mute_n;
    end
  end

endmodule

// File: tb/tb_hdmi_mode_switcher.sv
// Randomized scoreboard bench for hdmi_mode_switcher with three small timing generators
// and a switch-sequence reference model kept in the bench.
module tb_hdmi_mode_switcher;

  localparam int NM = 3;
  localparam int NC = 3;
  localparam int RC = 16;
  localparam int SF = 2;
  localparam logic [9:0] BLANK = 10'b1101010100;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           mode_req;
  logic [NM*NC*10-1:0]  tmds_in;
  logic [NM*11-1:0]     cx_in;
  logic [NM*10-1:0]     cy_in;
  logic [NC*10-1:0]     tmds_out;
  logic [10:0]          cx;
  logic [9:0]           cy;
  logic [NM-1:0]        mode_reset;
  logic [1:0]           active_mode;
  logic                 busy, audio_mute;

  hdmi_mode_switcher #(
    .NUM_MODES(NM), .NUM_CHANNELS(NC), .RESET_CYCLES(RC),
    .SETTLE_FRAMES(SF), .BLANK_SYMBOL(BLANK)
  ) dut (
    .clk_pixel(clk), .reset(reset), .mode_req(mode_req),
    .tmds_in(tmds_in), .cx_in(cx_in), .cy_in(cy_in),
    .tmds_out(tmds_out), .cx(cx), .cy(cy), .mode_reset(mode_reset),
    .active_mode(active_mode), .busy(busy), .audio_mute(audio_mute)
  );

  always #5 clk = ~clk;

  // Upstream timing generators: tiny rasters so frames are short.
  int htot [NM] = '{20, 17, 23};
  int vtot [NM] = '{6, 5, 4};
  int gx [NM];
  int gy [NM];

  always @(posedge clk) begin
    for (int m = 0; m < NM; m++) begin
      if (mode_reset[m] === 1'b1) begin
        gx[m] <= 0;
        gy[m] <= 0;
      end else if (gx[m] == htot[m] - 1) begin
        gx[m] <= 0;
        gy[m] <= (gy[m] == vtot[m] - 1) ? 0 : gy[m] + 1;
      end else begin
        gx[m] <= gx[m] + 1;
      end
    end
  end

  function automatic logic [9:0] pix(input int m, input int c, input int x, input int y);
    logic [1:0] mm, cc;
    logic [5:0] v;
    mm = 2'(m);
    cc = 2'(c);
    v  = 6'((x + 7 * y) % 64);
    return {mm, cc, v};
  endfunction

  always_comb begin
    tmds_in = '0;
    cx_in   = '0;
    cy_in   = '0;
    for (int m = 0; m < NM; m++) begin
      cx_in[m*11 +: 11] = 11'(gx[m]);
      cy_in[m*10 +: 10] = 10'(gy[m]);
      for (int c = 0; c < NC; c++) tmds_in[(m*NC+c)*10 +: 10] = pix(m, c, gx[m], gy[m]);
    end
  end

  typedef struct {
    logic [NC*10-1:0] tmds;
    logic [10:0]      cx;
    logic [9:0]       cy;
    logic [NM-1:0]    mr;
    logic [1:0]       am;
    logic             busy;
    logic             mute;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: which source is on the link, how long the reset hold still
  // lasts and how many new-mode frames still have to be thrown away.
  typedef enum {PH_HOLD, PH_WARM, PH_LIVE, PH_LEAVE} phase_t;
  phase_t m_ph = PH_HOLD;
  int m_cur = 0, m_tgt = 0, m_left = RC, m_frames_left = SF;

  function automatic bit origin(input int m);
    return (gx[m] == 0) && (gy[m] == 0);
  endfunction

  task automatic model_step();
    exp_t e;
    logic [NM-1:0] oh;
    int req;
    req = int'(mode_req);
    if (reset) begin
      m_ph   = PH_HOLD;
      m_tgt  = (req < NM) ? req : 0;
      m_cur  = 0;
      m_left = RC;
    end else begin
      case (m_ph)
        PH_LIVE:
          if (req != m_cur && req < NM) begin
            m_ph  = PH_LEAVE;
            m_tgt = req;
          end
        PH_LEAVE:
          if (req == m_cur) m_ph = PH_LIVE;
          else begin
            if (req < NM) m_tgt = req;
            if (origin(m_cur)) begin
              m_ph   = PH_HOLD;
              m_left = RC;
            end
          end
        PH_HOLD:
          if (m_left > 1) m_left--;
          else begin
            m_ph          = PH_WARM;
            m_frames_left = SF;
          end
        PH_WARM:
          if (origin(m_tgt)) begin
            m_frames_left--;
            if (m_frames_left == 0) begin
              m_ph  = PH_LIVE;
              m_cur = m_tgt;
            end
          end
      endcase
    end
    e.am = 2'(m_cur);
    if (m_ph == PH_LIVE || m_ph == PH_LEAVE) begin
      for (int c = 0; c < NC; c++) e.tmds[c*10 +: 10] = pix(m_cur, c, gx[m_cur], gy[m_cur]);
      e.cx = 11'(gx[m_cur]);
      e.cy = 10'(gy[m_cur]);
      oh = '0;
      oh[m_cur] = 1'b1;
      e.mr   = ~oh;
      e.busy = (m_ph == PH_LEAVE);
      e.mute = 1'b0;
    end else begin
      e.tmds = {NC{BLANK}};
      e.cx   = '0;
      e.cy   = '0;
      oh = '0;
      if (m_ph == PH_WARM) oh[m_tgt] = 1'b1;
      e.mr   = ~oh;
      e.busy = 1'b1;
      e.mute = 1'b1;
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: one registered output word per clock, compared just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("tmds_out",    64'(tmds_out),    64'(e.tmds));
      chk("cx",          64'(cx),          64'(e.cx));
      chk("cy",          64'(cy),          64'(e.cy));
      chk("mode_reset",  64'(mode_reset),  64'(e.mr));
      chk("active_mode", 64'(active_mode), 64'(e.am));
      chk("busy",        64'(busy),        64'(e.busy));
      chk("audio_mute",  64'(audio_mute),  64'(e.mute));
    end
  end

  task automatic step(input bit r, input int req);
    reset    = r;
    mode_req = 2'(req);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int req);
    repeat (n) step(1'b0, req);
  endtask

  task automatic run_until(input phase_t p, input int req, input int limit, input string what);
    int k = 0;
    while (m_ph != p && k < limit) begin
      step(1'b0, req);
      k++;
    end
    checks++;
    if (m_ph != p) begin
      errors++;
      $display("FAIL timeout_%s: phase %0d after %0d cycles, wanted %0d", what, m_ph, k, p);
    end
  endtask

  task automatic wait_x(input int m, input int x, input int req, input int limit);
    int k = 0;
    while (gx[m] != x && k < limit) begin
      step(1'b0, req);
      k++;
    end
    checks++;
    if (gx[m] != x) begin
      errors++;
      $display("FAIL timeout_cx: mode %0d cx %0d, wanted %0d", m, gx[m], x);
    end
  endtask

  initial begin
    int cur_req;
    // Power-up into mode 1.
    repeat (3) step(1'b1, 1);
    run_until(PH_LIVE, 1, 400, "boot");
    run(30, 1);
    // Switch to mode 0 from mid-frame.
    step(1'b0, 0);
    run_until(PH_LIVE, 0, 600, "to0");
    run(15, 0);
    // Mode 0 -> 1 requested mid-frame, drained to frame end.
    wait_x(0, 7, 0, 200);
    step(1'b0, 1);
    run_until(PH_LIVE, 1, 600, "to1");
    step(1'b0, 0);
    run_until(PH_LIVE, 0, 600, "back0");
    run(5, 0);
    // Drain abort: 0 -> 1 -> 0 before the boundary.
    wait_x(0, 3, 0, 200);
    step(1'b0, 1);
    step(1'b0, 1);
    run(20, 0);
    // Switch to mode 2, then an out-of-range request.
    step(1'b0, 2);
    run_until(PH_LIVE, 2, 600, "to2");
    run(200, 3);
    // Request changes during settle.
    step(1'b0, 0);
    run_until(PH_WARM, 0, 600, "settle0");
    run(3, 1);
    run(900, 1);
    // Reset in the middle of settle.
    step(1'b0, 2);
    run_until(PH_WARM, 2, 600, "settle2");
    run(10, 2);
    step(1'b1, 2);
    run(600, 2);
    // Random traffic with occasional resets and out-of-range requests.
    cur_req = 2;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) step(1'b1, cur_req);
      else begin
        if (r < 30) cur_req = $urandom_range(0, 3);
        step(1'b0, cur_req);
      end
    end
    run(5, cur_req);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected words never compared, wanted 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
